// File: rtl/s2_hazard_control.sv
// s2_hazard_control: stage-2 decode, forwarding selects and load-use stall
// for the three-stage RV32I core; tracks the two younger destination registers.
module s2_hazard_control #(
  parameter int FWD_DEPTH = 2,
  parameter int HAS_MUL   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_s2,
  input  logic        valid_s2,
  input  logic        flush,
  output logic [3:0]  alu_sel,
  output logic        a_sel,
  output logic        b_sel,
  output logic        brun,
  output logic        mem_wen,
  output logic        csr_we,
  output logic [1:0]  rs1_sel,
  output logic [1:0]  rs2_sel,
  output logic        stall
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  logic [6:0] op;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  logic is_r, is_i, is_csr, is_mul, writes_rd, uses_rs1, uses_rs2;
  logic live, hazard, issue, s4_live;
  logic s3_v_q, s3_v_d, s3_ld_q, s3_ld_d, s4_v_q, s4_v_d, cnt_q, cnt_d;
  logic [4:0] s3_rd_q, s3_rd_d, s4_rd_q, s4_rd_d;
  assign op     = instr_s2[6:0];
  assign f3     = instr_s2[14:12];
  assign rd     = instr_s2[11:7];
  assign rs1    = instr_s2[19:15];
  assign rs2    = instr_s2[24:20];
  assign is_r   = op == OP_REG;
  assign is_i   = op == OP_IMM;
  assign is_csr = op == OP_SYSTEM && f3 != 3'd0;
  assign is_mul = HAS_MUL != 0 && is_r && instr_s2[31:25] == 7'b0000001;
  always_comb begin
    alu_sel = 4'd0;
    if (op == OP_LUI) alu_sel = 4'd15;
    else if (is_mul)
      alu_sel = f3 == 3'd0 ? 4'd3 : f3 == 3'd1 ? 4'd8 : f3 == 3'd2 ? 4'd9 : f3 == 3'd3 ? 4'd10 : 4'd0;
    else if (is_r || is_i)
      case (f3)
        3'd0: alu_sel = (is_r && instr_s2[30]) ? 4'd12 : 4'd0;
        3'd1: alu_sel = 4'd1;
        3'd2: alu_sel = 4'd2;
        3'd3: alu_sel = 4'd11;
        3'd4: alu_sel = 4'd4;
        3'd5: alu_sel = instr_s2[30] ? 4'd13 : 4'd5;
        3'd6: alu_sel = 4'd6;
        default: alu_sel = 4'd7;
      endcase
  end
  assign a_sel     = op == OP_AUIPC || op == OP_JAL || op == OP_BRANCH;
  assign b_sel     = !is_r;
  assign brun      = instr_s2[13];
  assign writes_rd = rd != 5'd0 && (op == OP_LUI || op == OP_AUIPC || op == OP_JAL || op == OP_JALR ||
                     op == OP_LOAD || is_r || is_i || is_csr);
  assign uses_rs1  = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  assign uses_rs2  = is_r || op == OP_STORE || op == OP_BRANCH;
  assign live      = valid_s2 & ~flush;
  assign hazard    = live & s3_v_q & s3_ld_q &
                     ((uses_rs1 && rs1 == s3_rd_q) || (uses_rs2 && rs2 == s3_rd_q));
  // Without a writeback forward path the load must fully retire, so hold one extra cycle.
  assign stall     = hazard | (live & cnt_q);
  assign issue     = live & ~stall;
  assign mem_wen   = issue & (op == OP_STORE);
  assign csr_we    = issue & is_csr;
  assign s4_live   = FWD_DEPTH == 2 && s4_v_q;
  assign rs1_sel = (!uses_rs1 || rs1 == 5'd0) ? 2'b10 :
                   (s3_v_q && !s3_ld_q && s3_rd_q == rs1) ? 2'b00 :
                   (s4_live && s4_rd_q == rs1) ? 2'b01 : 2'b10;
  assign rs2_sel = (!uses_rs2 || rs2 == 5'd0) ? 2'b10 :
                   (s3_v_q && !s3_ld_q && s3_rd_q == rs2) ? 2'b00 :
                   (s4_live && s4_rd_q == rs2) ? 2'b01 : 2'b10;
  assign s3_v_d  = issue & writes_rd;
  assign s3_rd_d = rd;
  assign s3_ld_d = op == OP_LOAD;
  assign s4_v_d  = s3_v_q;
  assign s4_rd_d = s3_rd_q;
  assign cnt_d   = FWD_DEPTH == 1 && hazard;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_v_q  <= 1'b0;
      s3_rd_q <= 5'd0;
      s3_ld_q <= 1'b0;
      s4_v_q  <= 1'b0;
      s4_rd_q <= 5'd0;
      cnt_q   <= 1'b0;
    end else begin
      s3_v_q  <= s3_v_d;
      s3_rd_q <= s3_rd_d;
      s3_ld_q <= s3_ld_d;
      s4_v_q  <= s4_v_d;
      s4_rd_q <= s4_rd_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: doc/s2_hazard_control.md
# s2_hazard_control

Parametrised second-generation stage-2 (execute) control unit for the three-stage RV32I core. It decodes the stage-2 instruction into ALU, operand-select, branch and memory controls, and optionally decodes RV32M multiply ops. It also tracks destination registers of the two younger-stage instructions to drive forwarding selects. It detects load-use hazards and inserts a one-cycle stall, and it accepts a flush from branch/jump resolution.

## Interface
- `FWD_DEPTH`, 2: forwarding sources tracked; 1 = stage 3 only, 2 = stage 3 and writeback (stage 4).
- `HAS_MUL`, 0: 1 enables RV32M multiply decode (funct7 = 7'b0000001 on R-type).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr_s2`  in  32  instruction currently in stage 2.
- `valid_s2`  in  1  `instr_s2` is a real instruction (not a bubble).
- `flush`  in  1  kill the stage-2 instruction (taken branch/jump resolved this cycle).
- `alu_sel`  out  4  ALU op code.
- `a_sel`, `b_sel`  out  1 each  operand A = PC when 1; operand B = immediate when 1.
- `brun`  out  1  unsigned branch compare (`instr_s2[13]`).
- `mem_wen`, `csr_we`  out  1 each  store enable; CSR write enable.
- `rs1_sel`, `rs2_sel`  out  2 each  forwarding select: 2'b00 = stage-3 result, 2'b01 = writeback result, 2'b10 = register file.
- `stall`  out  1  hold PC and stage 2 this cycle; a bubble enters stage 3.

## Operation
- Decode (combinational, from `instr_s2`):
  - `a_sel`=1 for AUIPC, JAL, BRANCH.
  - `b_sel`=0 only for R-type.
  - `mem_wen`, `csr_we` and `writes_rd` are gated by `valid_s2 & ~flush & ~stall`.
- `alu_sel` codes:
  - ADD=0, SLL=1, SLT=2, XOR=4, SRL=5, OR=6, AND=7, SLTU=11, SUB=12, SRA=13, LUI pass-B=15.
  - CSR, AUIPC, JAL, JALR, BRANCH, LOAD and STORE all use 0. Unknown opcodes use 0. No latch: default assignment first.
  - SUB requires R-type with bit30 set. I-type func3 000 is always ADD, whatever bit30 is. SRAI/SRA are selected by bit30.
  - With HAS_MUL=1 and R-type funct7=0000001: MUL=3, MULH=8, MULHSU=9, MULHU=10. func3 1xx (div/rem) decodes to 0.
  - With HAS_MUL=0, funct7 bit25 is ignored.
- `writes_rd`: set for LUI, AUIPC, JAL, JALR, LOAD, R-type, I-type and CSR, and only when rd ≠ 0.
- `uses_rs1`: every opcode except LUI, AUIPC and JAL. `uses_rs2`: R-type, STORE, BRANCH.
- Tracking registers:
  - S3 = {v, rd, is_load}; S4 = {v, rd} (S4 exists only if FWD_DEPTH=2).
  - Each edge: S4 ← S3, and S3 ← {valid_s2 & ~flush & ~stall & writes_rd, rd, opcode==LOAD}.
- Forwarding, per rs:
  - Not used, or rs = 0 → 2'b10.
  - Else S3.v & S3.rd==rs & ~S3.is_load → 2'b00.
  - Else S4.v & S4.rd==rs → 2'b01.
  - Else 2'b10.
  - S3 has priority over S4.
- Load-use: `stall` = valid_s2 & ~flush & S3.v & S3.is_load & (rs1 or rs2 used and equal to S3.rd).
  - The next cycle sees the load in S4, so the stall is exactly one cycle and then the select is 2'b01.
  - With FWD_DEPTH=1, a load-use stalls 2 cycles. A stall counter holds the instruction until the load has retired, and the register file then supplies the value (2'b10).
- Simultaneous flush and hazard: flush wins; `stall`=0 and a bubble enters S3.

## Timing
- All outputs are combinational from `instr_s2` and the tracking registers. Zero-cycle decode latency.
- Reset (rst_n low, asynchronous): S3.v = S4.v = 0 and the stall counter = 0.
  - Hence `stall`=0 and `rs*_sel` = 2'b10.
  - With `valid_s2`=0: `mem_wen`=`csr_we`=0.
- Reset asserted mid-stall clears the stall in the same cycle (asynchronous).
- The first edge after rst_n rises may load S3.

## Test plan
- Back-to-back dependency: `addi x1,x0,5` (0x00500093) then `add x2,x1,x1` (0x00108133) -> cycle 2: `rs1_sel`=`rs2_sel`=2'b00, `stall`=0.
- Load-use: `lw x3,0(x0)` (0x00002183) then `add x4,x3,x0` (0x00018233) -> `stall`=1 for one cycle, then `rs1_sel`=2'b01, `rs2_sel`=2'b10. With FWD_DEPTH=1: two stall cycles, then 2'b10.
- Negative immediate: `addi x1,x0,-1` (0xFFF00093) -> `alu_sel`=0, `b_sel`=1.
- x0 and flush: `addi x0,x0,1` (0x00100013) then `add x2,x0,x0` (0x00000133) -> selects 2'b10. Also, assert `flush` on `addi x1,...`; the next `add x2,x1,x1` -> selects 2'b10.
- Multiply: `mul x5,x1,x2` (0x022082B3) -> `alu_sel`=3 with HAS_MUL=1, and 0 with HAS_MUL=0.
- Reset mid-stall: drop `rst_n` during the load-use stall -> `stall`=0 and selects = 2'b10 immediately.
